// File: rtl/core_pkg.sv
// =============================================================================
// core_pkg : shared encodings and defaults for the core pipeline control
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package core_pkg;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    typedef enum logic [1:0] {
        S_RUN      = RUN,
        S_DIV_BUSY = DIV_BUSY,
        S_MEM_WAIT = MEM_WAIT
    } state_t;

    localparam logic [4:0] C_REG_ZERO            = 5'd0;
    localparam int         C_CNT_W_DEFAULT       = 32;
    localparam int         C_DIV_TIMEOUT_DEFAULT = 64;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// =============================================================================
// hazard_detect : combinational load-use comparator between EX and ID
// Revision      : 1.0 - initial release
// =============================================================================
`default_nettype none

module hazard_detect
    import core_pkg::*;
(
    input  logic       i_ex_valid,
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1_addr,
    input  logic [4:0] i_id_rs2_addr,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1_addr == i_ex_rd);
    assign w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2_addr == i_ex_rd);

    // x0 is never written, so a load targeting it cannot create a hazard
    assign o_load_use = i_ex_valid && i_ex_is_load && (i_ex_rd != C_REG_ZERO)
                        && i_id_valid && (w_rs1_hit || w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// =============================================================================
// pipeline_ctrl : stall / bubble / flush sequencing for the 5-stage core
// Revision      : 1.0 - initial release
// =============================================================================
`default_nettype none

module pipeline_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W       = C_CNT_W_DEFAULT,
    parameter int DIV_TIMEOUT = C_DIV_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_div_instruction,
    input  logic             div_busy,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_pc_target,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             div_start,
    output logic             pc_load,
    output logic [31:0]      pc_target,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             mem_wb_bubble,
    output logic             div_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                DCNT_W      = $clog2(DIV_TIMEOUT + 1);
    localparam logic [DCNT_W-1:0] C_DIV_LIMIT = DCNT_W'(DIV_TIMEOUT);

    state_t            r_state, w_state_nxt, w_eff_state;
    logic              r_div_pend, w_div_pend_nxt;
    logic [DCNT_W-1:0] r_div_cnt, w_div_cnt_nxt, w_div_cnt_inc;
    logic              r_div_timeout, w_timeout_set;
    logic [CNT_W-1:0]  r_stall_cycles, r_flush_count;
    logic              w_mem_hold, w_load_use;

    logic w_div_start, w_pc_load, w_pc_stall, w_if_id_stall, w_id_ex_stall;
    logic w_ex_mem_stall, w_if_id_flush, w_id_ex_bubble, w_ex_mem_bubble;
    logic w_mem_wb_bubble;

    hazard_detect u_hazard_detect (
        .i_ex_valid    (ex_valid),
        .i_ex_is_load  (ex_is_load),
        .i_ex_rd       (ex_rd),
        .i_id_valid    (id_valid),
        .i_id_rs1_addr (id_rs1_addr),
        .i_id_rs2_addr (id_rs2_addr),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .o_load_use    (w_load_use)
    );

    assign w_mem_hold    = mem_req && !mem_ready;
    assign w_div_cnt_inc = (r_div_cnt == C_DIV_LIMIT) ? r_div_cnt : r_div_cnt + DCNT_W'(1);

    always_comb begin
        // Once the memory hold clears, MEM_WAIT behaves as the state it interrupted
        w_eff_state = r_state;
        if (r_state == S_MEM_WAIT) begin
            w_eff_state = r_div_pend ? S_DIV_BUSY : S_RUN;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_div_pend_nxt  = r_div_pend;
        w_div_cnt_nxt   = r_div_cnt;
        w_timeout_set   = 1'b0;
        w_div_start     = 1'b0;
        w_pc_load       = 1'b0;
        w_pc_stall      = 1'b0;
        w_if_id_stall   = 1'b0;
        w_id_ex_stall   = 1'b0;
        w_ex_mem_stall  = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_mem_wb_bubble = 1'b0;

        if (reset) begin
            w_state_nxt = S_RUN;
        end else if (w_mem_hold) begin
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_stall   = 1'b1;
            w_ex_mem_stall  = 1'b1;
            w_mem_wb_bubble = 1'b1;
            w_state_nxt     = S_MEM_WAIT;
            w_div_pend_nxt  = (w_eff_state == S_DIV_BUSY);
        end else begin
            case (w_eff_state)
                S_DIV_BUSY: begin
                    if (!div_busy || (w_div_cnt_inc == C_DIV_LIMIT)) begin
                        w_timeout_set  = div_busy;
                        w_state_nxt    = S_RUN;
                        w_div_pend_nxt = 1'b0;
                        w_div_cnt_nxt  = '0;
                    end else begin
                        w_pc_stall      = 1'b1;
                        w_if_id_stall   = 1'b1;
                        w_id_ex_stall   = 1'b1;
                        w_ex_mem_bubble = 1'b1;
                        w_state_nxt     = S_DIV_BUSY;
                        w_div_cnt_nxt   = w_div_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt    = S_RUN;
                    w_div_pend_nxt = 1'b0;
                    if (ex_valid && ex_div_instruction) begin
                        w_div_start     = 1'b1;
                        w_pc_stall      = 1'b1;
                        w_if_id_stall   = 1'b1;
                        w_id_ex_stall   = 1'b1;
                        w_ex_mem_bubble = 1'b1;
                        w_state_nxt     = S_DIV_BUSY;
                        w_div_cnt_nxt   = '0;
                    end else if (ex_valid && ex_redirect) begin
                        w_pc_load      = 1'b1;
                        w_if_id_flush  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_stall     = 1'b1;
                        w_if_id_stall  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_RUN;
            r_div_pend     <= 1'b0;
            r_div_cnt      <= '0;
            r_div_timeout  <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_div_pend     <= w_div_pend_nxt;
            r_div_cnt      <= w_div_cnt_nxt;
            r_div_timeout  <= r_div_timeout | w_timeout_set;
            r_stall_cycles <= r_stall_cycles + CNT_W'(w_pc_stall);
            r_flush_count  <= r_flush_count + CNT_W'(w_pc_load);
        end
    end

    assign div_start     = w_div_start;
    assign pc_load       = w_pc_load;
    assign pc_target     = reset ? 32'd0 : ex_pc_target;
    assign pc_stall      = w_pc_stall;
    assign if_id_stall   = w_if_id_stall;
    assign id_ex_stall   = w_id_ex_stall;
    assign ex_mem_stall  = w_ex_mem_stall;
    assign if_id_flush   = w_if_id_flush;
    assign id_ex_bubble  = w_id_ex_bubble;
    assign ex_mem_bubble = w_ex_mem_bubble;
    assign mem_wb_bubble = w_mem_wb_bubble;
    assign div_timeout   = r_div_timeout;
    assign stall_cycles  = r_stall_cycles;
    assign flush_count   = r_flush_count;

endmodule

`default_nettype wire
